// File: rtl/snake_pkg.sv
// Shared grid, direction and state definitions for the snake movement engine.
package snake_pkg;

  localparam int unsigned GRID_W  = 64;
  localparam int unsigned GRID_H  = 48;
  localparam int unsigned COORD_W = 6;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  // Encoding pairs opposites on bit 0, so reversal is a single bit flip.
  function automatic dir_t opposite_dir(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_step_tick.sv
// Step-rate divider: counts 0..STEP_DIV-1 while enabled, flags the last count.
module snake_step_tick #(
  parameter int unsigned STEP_DIV = 20_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running step counter, held at zero while cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick_c = en && (cnt == LAST);

endmodule

// File: rtl/snake_motion_engine.sv
// Snake movement engine: direction latching, stepping, wall handling.
// Build option: define SNAKE_WRAP_EN to wrap the head around the grid edges
// instead of ending the game on a wall hit.
module snake_motion_engine
  import snake_pkg::*;
#(
  parameter int unsigned STEP_DIV = 20_000_000,
  parameter int unsigned START_X  = 32,
  parameter int unsigned START_Y  = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [5:0] Px1,
  output logic [5:0] Px2,
  output logic [5:0] Px3,
  output logic [5:0] Px4,
  output logic [5:0] Py1,
  output logic [5:0] Py2,
  output logic [5:0] Py3,
  output logic [5:0] Py4,
  output logic       alive,
  output logic       step_pulse
);

  localparam logic [COORD_W-1:0] SX0 = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] SX1 = COORD_W'(START_X - 1);
  localparam logic [COORD_W-1:0] SX2 = COORD_W'(START_X - 2);
  localparam logic [COORD_W-1:0] SX3 = COORD_W'(START_X - 3);
  localparam logic [COORD_W-1:0] SY  = COORD_W'(START_Y);

  state_t             state;
  dir_t               cur_dir;
  dir_t               next_dir;
  dir_t               req_dir;
  dir_t               dir_c;
  logic               req_valid;
  logic               run;
  logic               tick_c;
  logic               move_ok_c;
  logic [COORD_W:0]   hx;
  logic [COORD_W:0]   hy;
  logic [COORD_W-1:0] new_x;
  logic [COORD_W-1:0] new_y;

  assign run = (state == ST_RUN);

  snake_step_tick #(.STEP_DIV(STEP_DIV)) u_step_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (!run),
    .en     (run),
    .tick_c (tick_c)
  );

  // Button arbitration, reversal filter and candidate head position.
  always_comb begin
    req_dir   = DIR_RIGHT;
    req_valid = 1'b1;
    if (btn_up)         req_dir = DIR_UP;
    else if (btn_down)  req_dir = DIR_DOWN;
    else if (btn_left)  req_dir = DIR_LEFT;
    else if (btn_right) req_dir = DIR_RIGHT;
    else                req_valid = 1'b0;

    dir_c = next_dir;
    if (req_valid && (req_dir != opposite_dir(cur_dir))) dir_c = req_dir;

    hx = {1'b0, Px1};
    hy = {1'b0, Py1};
    case (dir_c)
      DIR_UP:    hy = hy - 7'd1;
      DIR_DOWN:  hy = hy + 7'd1;
      DIR_LEFT:  hx = hx - 7'd1;
      DIR_RIGHT: hx = hx + 7'd1;
    endcase

`ifdef SNAKE_WRAP_EN
    move_ok_c = 1'b1;
    if (hx[COORD_W]) new_x = (Px1 == '0) ? COORD_W'(GRID_W - 1) : '0;
    else             new_x = hx[COORD_W-1:0];
    if (hy >= 7'(GRID_H)) new_y = (Py1 == '0) ? COORD_W'(GRID_H - 1) : '0;
    else                  new_y = hy[COORD_W-1:0];
`else
    move_ok_c = !(hx[COORD_W] || (hy >= 7'(GRID_H)));
    new_x     = hx[COORD_W-1:0];
    new_y     = hy[COORD_W-1:0];
`endif
  end

  // Game state, direction registers and segment shift on each step tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cur_dir    <= DIR_RIGHT;
      next_dir   <= DIR_RIGHT;
      Px1 <= SX0; Px2 <= SX1; Px3 <= SX2; Px4 <= SX3;
      Py1 <= SY;  Py2 <= SY;  Py3 <= SY;  Py4 <= SY;
      alive      <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      case (state)
        ST_IDLE, ST_DEAD: begin
          if (start) begin
            state    <= ST_RUN;
            cur_dir  <= DIR_RIGHT;
            next_dir <= DIR_RIGHT;
            Px1 <= SX0; Px2 <= SX1; Px3 <= SX2; Px4 <= SX3;
            Py1 <= SY;  Py2 <= SY;  Py3 <= SY;  Py4 <= SY;
            alive    <= 1'b1;
          end
        end
        ST_RUN: begin
          next_dir <= dir_c;
          if (tick_c) begin
            cur_dir <= dir_c;
            if (move_ok_c) begin
              Px4 <= Px3; Py4 <= Py3;
              Px3 <= Px2; Py3 <= Py2;
              Px2 <= Px1; Py2 <= Py1;
              Px1 <= new_x; Py1 <= new_y;
              step_pulse <= 1'b1;
            end else begin
              state <= ST_DEAD;
              alive <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_motion_engine.sv
// Directed bench for snake_motion_engine with STEP_DIV=4.
// Wall expectations follow SNAKE_WRAP_EN when the bench is built with it.
module tb_snake_motion_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [5:0] Px1, Px2, Px3, Px4, Py1, Py2, Py3, Py4;
  logic       alive, step_pulse;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic       start, up, down, left, right;
    logic [5:0] px1, py1, px2, py2, px3, py3, px4, py4;
    logic       alive, pulse;
  } vec_t;

  vec_t vecs[25];

  snake_motion_engine #(.STEP_DIV(4), .START_X(32), .START_Y(24)) dut (
    .clk(clk), .rst(rst), .start(start),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .Px1(Px1), .Px2(Px2), .Px3(Px3), .Px4(Px4),
    .Py1(Py1), .Py2(Py2), .Py3(Py3), .Py4(Py4),
    .alive(alive), .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, u, d, l, r,
                              input int x1, y1, x2, y2, x3, y3, x4, y4,
                              input logic a, p);
    vec_t v;
    v.start = s; v.up = u; v.down = d; v.left = l; v.right = r;
    v.px1 = 6'(x1); v.py1 = 6'(y1); v.px2 = 6'(x2); v.py2 = 6'(y2);
    v.px3 = 6'(x3); v.py3 = 6'(y3); v.px4 = 6'(x4); v.py4 = 6'(y4);
    v.alive = a; v.pulse = p;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock with the given inputs; returns just after the rising edge.
  task automatic cyc(input logic s, u, d, l, r);
    @(negedge clk);
    start = s; btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return 64'({Px1, Py1, Px2, Py2, Px3, Py3, Px4, Py4, alive, step_pulse});
  endfunction

  function automatic logic [63:0] exp_of(input vec_t v);
    return 64'({v.px1, v.py1, v.px2, v.py2, v.px3, v.py3, v.px4, v.py4, v.alive, v.pulse});
  endfunction

  initial begin
    // Rows: inputs held for one clock, expected outputs after that edge.
    vecs[0]  = mk(1,0,0,0,0, 32,24, 31,24, 30,24, 29,24, 1,0);
    vecs[1]  = mk(0,0,0,0,0, 32,24, 31,24, 30,24, 29,24, 1,0);
    vecs[2]  = mk(0,0,0,0,0, 32,24, 31,24, 30,24, 29,24, 1,0);
    vecs[3]  = mk(0,0,0,0,0, 32,24, 31,24, 30,24, 29,24, 1,0);
    vecs[4]  = mk(0,0,0,0,0, 33,24, 32,24, 31,24, 30,24, 1,1);
    vecs[5]  = mk(0,0,0,1,0, 33,24, 32,24, 31,24, 30,24, 1,0);
    vecs[6]  = mk(0,1,0,0,0, 33,24, 32,24, 31,24, 30,24, 1,0);
    vecs[7]  = mk(0,0,0,0,0, 33,24, 32,24, 31,24, 30,24, 1,0);
    vecs[8]  = mk(0,0,0,0,0, 33,23, 33,24, 32,24, 31,24, 1,1);
    vecs[9]  = mk(0,0,0,0,1, 33,23, 33,24, 32,24, 31,24, 1,0);
    vecs[10] = mk(0,0,0,0,0, 33,23, 33,24, 32,24, 31,24, 1,0);
    vecs[11] = mk(0,0,0,0,0, 33,23, 33,24, 32,24, 31,24, 1,0);
    vecs[12] = mk(0,0,0,0,0, 34,23, 33,23, 33,24, 32,24, 1,1);
    vecs[13] = mk(0,1,0,0,1, 34,23, 33,23, 33,24, 32,24, 1,0);
    vecs[14] = mk(0,0,0,0,0, 34,23, 33,23, 33,24, 32,24, 1,0);
    vecs[15] = mk(0,0,0,0,0, 34,23, 33,23, 33,24, 32,24, 1,0);
    vecs[16] = mk(0,0,0,0,0, 34,22, 34,23, 33,23, 33,24, 1,1);
    vecs[17] = mk(0,0,1,0,0, 34,22, 34,23, 33,23, 33,24, 1,0);
    vecs[18] = mk(1,0,0,0,0, 34,22, 34,23, 33,23, 33,24, 1,0);
    vecs[19] = mk(0,0,0,0,0, 34,22, 34,23, 33,23, 33,24, 1,0);
    vecs[20] = mk(0,0,0,0,0, 34,21, 34,22, 34,23, 33,23, 1,1);
    vecs[21] = mk(0,0,0,0,0, 34,21, 34,22, 34,23, 33,23, 1,0);
    vecs[22] = mk(0,0,0,0,0, 34,21, 34,22, 34,23, 33,23, 1,0);
    vecs[23] = mk(0,0,0,0,0, 34,21, 34,22, 34,23, 33,23, 1,0);
    vecs[24] = mk(0,0,0,1,0, 33,21, 34,21, 34,22, 34,23, 1,1);

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_layout", outs(),
          exp_of(mk(0,0,0,0,0, 32,24, 31,24, 30,24, 29,24, 0,0)));
    rst = 1'b0;
    cyc(0,0,0,0,0);
    check("idle_hold", outs(),
          exp_of(mk(0,0,0,0,0, 32,24, 31,24, 30,24, 29,24, 0,0)));

    // Table-driven main sequence.
    for (int i = 0; i < 25; i++) begin
      cyc(vecs[i].start, vecs[i].up, vecs[i].down, vecs[i].left, vecs[i].right);
      check($sformatf("vec%0d", i), outs(), exp_of(vecs[i]));
    end

    // Reset two cycles ahead of a tick: layout restored, no later move.
    cyc(0,0,0,0,0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async", outs(),
          exp_of(mk(0,0,0,0,0, 32,24, 31,24, 30,24, 29,24, 0,0)));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(0,0,0,0,0);
      check($sformatf("rst_nomove%0d", i), outs(),
            exp_of(mk(0,0,0,0,0, 32,24, 31,24, 30,24, 29,24, 0,0)));
    end

    // Run head right to column 63.
    cyc(1,0,0,0,0);
    check("wall_start_alive", 64'(alive), 64'(1));
    for (int k = 1; k <= 31; k++) begin
      repeat (4) cyc(0,0,0,0,0);
      check($sformatf("wall_run%0d", k), 64'({Px1, step_pulse}), 64'({6'(32 + k), 1'b1}));
    end
    repeat (4) cyc(0,0,0,0,0);
`ifdef SNAKE_WRAP_EN
    check("wrap_x", 64'({Px1, Px2, Py1, alive, step_pulse}),
          64'({6'd0, 6'd63, 6'd24, 1'b1, 1'b1}));
`else
    check("dead_x", 64'({Px1, Px2, Py1, alive, step_pulse}),
          64'({6'd63, 6'd62, 6'd24, 1'b0, 1'b0}));
    repeat (5) cyc(0,0,0,0,0);
    check("dead_frozen", 64'({Px1, Px4, alive, step_pulse}),
          64'({6'd63, 6'd60, 1'b0, 1'b0}));
    cyc(1,0,0,0,0);
    check("restart", outs(),
          exp_of(mk(0,0,0,0,0, 32,24, 31,24, 30,24, 29,24, 1,0)));
`endif

    // Turn up and run to row 0, then one more step.
    cyc(0,1,0,0,0);
    repeat (3) cyc(0,0,0,0,0);
    check("up_run1", 64'({Py1, step_pulse}), 64'({6'd23, 1'b1}));
    for (int k = 2; k <= 24; k++) begin
      repeat (4) cyc(0,0,0,0,0);
      check($sformatf("up_run%0d", k), 64'({Py1, step_pulse}), 64'({6'(24 - k), 1'b1}));
    end
    repeat (4) cyc(0,0,0,0,0);
`ifdef SNAKE_WRAP_EN
    check("wrap_y", 64'({Py1, Py2, alive, step_pulse}),
          64'({6'd47, 6'd0, 1'b1, 1'b1}));
`else
    check("dead_y", 64'({Py1, Py2, alive, step_pulse}),
          64'({6'd0, 6'd1, 1'b0, 1'b0}));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
